mprj_io_cfg_loader: RTL and testbench

MPRJ_IO_CFG_LOADER -- requirements
Module: mprj_io_cfg_loader

---
 rtl/mprj_cfg_pkg.sv | 33 +++
 rtl/mprj_cfg_phase_timer.sv | 33 +++
 rtl/mprj_io_cfg_loader.sv | 128 ++++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mprj_cfg_pkg.sv
// Shared definitions for the user-pad configuration chain loader.
// Holds per-pad field offsets, the default word width and the loader state encoding.
package mprj_cfg_pkg;

   localparam int CFG_BITS_DEF    = 13;

   // Bit offsets of each field within one pad's configuration word
   localparam int CFG_MGMT_EN     = 0;
   localparam int CFG_OUT_DIS     = 1;
   localparam int CFG_HOLDOVER    = 2;
   localparam int CFG_INP_DIS     = 3;
   localparam int CFG_IB_MODE_SEL = 4;
   localparam int CFG_ANALOG_EN   = 5;
   localparam int CFG_ANALOG_SEL  = 6;
   localparam int CFG_ANALOG_POL  = 7;
   localparam int CFG_SLOW_SEL    = 8;
   localparam int CFG_VTRIP_SEL   = 9;
   localparam int CFG_DM_LSB      = 10;
   localparam int CFG_DM_MSB      = 12;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT_LO = 3'd1,
      ST_SHIFT_HI = 3'd2,
      ST_LOAD     = 3'd3,
      ST_DONE     = 3'd4
   } cfg_state_e;

   function automatic logic is_busy_state(input cfg_state_e s);
      return !((s == ST_IDLE) || (s == ST_DONE));
   endfunction

endpackage

// File: rtl/mprj_cfg_phase_timer.sv
// Half-period down-counter for the serial chain clock.
// Reloads to HALF_PERIOD-1 on restart and parks at zero; tc is high while the count is zero.
module mprj_cfg_phase_timer #(
   parameter int HALF_PERIOD = 1
) (
   input  logic clock,
   input  logic resetb,
   input  logic restart,
   output logic tc
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = 8'(HALF_PERIOD - 1);
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == 8'd0);

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Serialises a snapshot of every pad's configuration word into the pad chain, then strobes load.
// All outputs are flopped from the next-state decode so they line up with the state register.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for xfer_start, chain outputs held low
//   SHIFT_LO | current bit driven, serial_clock low for HALF_PERIOD
//   SHIFT_HI | serial_clock high for HALF_PERIOD, chain captures the bit
//   LOAD     | serial_load high for HALF_PERIOD after the last bit
//   DONE     | one-cycle done pulse, then back to IDLE
module mprj_io_cfg_loader
   import mprj_cfg_pkg::*;
#(
   parameter int MPRJ_IO_PADS = 38,
   parameter int CFG_BITS     = CFG_BITS_DEF,
   parameter int HALF_PERIOD  = 1
) (
   input  logic                             clock,
   input  logic                             resetb,
   input  logic                             xfer_start,
   input  logic [MPRJ_IO_PADS*CFG_BITS-1:0] cfg_data,
   output logic                             busy,
   output logic                             done,
   output logic                             serial_clock,
   output logic                             serial_data,
   output logic                             serial_load
);

   localparam int TOTAL = MPRJ_IO_PADS * CFG_BITS;
   localparam int BCW   = $clog2(TOTAL + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(TOTAL - 1);

   cfg_state_e       state_q, state_d;
   logic [TOTAL-1:0] shift_q, shift_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sclk_q, sclk_d;
   logic             sdata_q, sdata_d;
   logic             sload_q, sload_d;
   logic             phase_tc, phase_restart;

   mprj_cfg_phase_timer #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_phase_timer (
      .clock   (clock),
      .resetb  (resetb),
      .restart (phase_restart),
      .tc      (phase_tc)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer_start) begin
               shift_d   = cfg_data;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT_LO;
            end
         end
         ST_SHIFT_LO: begin
            if (phase_tc) state_d = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (phase_tc) begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_LOAD;
               end else begin
                  // Data only moves on the falling edge of serial_clock
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  shift_d   = {shift_q[TOTAL-2:0], 1'b0};
                  state_d   = ST_SHIFT_LO;
               end
            end
         end
         ST_LOAD: begin
            if (phase_tc) state_d = ST_DONE;
         end
         ST_DONE: begin
            bit_cnt_d = '0;
            shift_d   = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      phase_restart = (state_d != state_q) &&
                      (state_d inside {ST_SHIFT_LO, ST_SHIFT_HI, ST_LOAD});

      busy_d  = is_busy_state(state_d);
      done_d  = (state_d == ST_DONE);
      sclk_d  = (state_d == ST_SHIFT_HI);
      sload_d = (state_d == ST_LOAD);
      sdata_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? shift_d[TOTAL-1] : 1'b0;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         sdata_q   <= 1'b0;
         sload_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         sdata_q   <= sdata_d;
         sload_q   <= sload_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign serial_clock = sclk_q;
   assign serial_data  = sdata_q;
   assign serial_load  = sload_q;

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Directed bench for the pad configuration loader: a 2-pad chain, the default chain and a slow-clock chain.
module tb_mprj_io_cfg_loader;

   logic         clock = 1'b0;
   logic         resetb = 1'b1;
   logic [2:0]   xs = 3'b000;
   logic [2:0]   busy_v, done_v, sck_v, sda_v, sld_v;
   logic [25:0]  cfg_s = '0;
   logic [493:0] cfg_d = '0;
   logic [493:0] cfg_h = '0;
   int           n_chk = 0;
   int           n_fail = 0;

   always #5 clock = ~clock;

   mprj_io_cfg_loader #(.MPRJ_IO_PADS(2), .CFG_BITS(13), .HALF_PERIOD(1)) u_small (
      .clock(clock), .resetb(resetb), .xfer_start(xs[0]), .cfg_data(cfg_s),
      .busy(busy_v[0]), .done(done_v[0]), .serial_clock(sck_v[0]),
      .serial_data(sda_v[0]), .serial_load(sld_v[0]));

   mprj_io_cfg_loader #(.MPRJ_IO_PADS(38), .CFG_BITS(13), .HALF_PERIOD(1)) u_def (
      .clock(clock), .resetb(resetb), .xfer_start(xs[1]), .cfg_data(cfg_d),
      .busy(busy_v[1]), .done(done_v[1]), .serial_clock(sck_v[1]),
      .serial_data(sda_v[1]), .serial_load(sld_v[1]));

   mprj_io_cfg_loader #(.MPRJ_IO_PADS(38), .CFG_BITS(13), .HALF_PERIOD(3)) u_hp3 (
      .clock(clock), .resetb(resetb), .xfer_start(xs[2]), .cfg_data(cfg_h),
      .busy(busy_v[2]), .done(done_v[2]), .serial_clock(sck_v[2]),
      .serial_data(sda_v[2]), .serial_load(sld_v[2]));

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {busy, done, serial_clock, serial_data, serial_load} of instance s
   function automatic logic [4:0] outs(input int s);
      return {busy_v[s], done_v[s], sck_v[s], sda_v[s], sld_v[s]};
   endfunction

   task automatic set_cfg(input int s, input logic [493:0] v);
      case (s)
         0: cfg_s = v[25:0];
         1: cfg_d = v;
         default: cfg_h = v;
      endcase
   endtask

   function automatic logic [493:0] pat(input int seed);
      logic [493:0] v;
      v = '0;
      for (int i = 0; i < 38; i++) v[i*13 +: 13] = 13'(seed * 131 + i * (seed + 17));
      return v;
   endfunction

   task automatic xfer(input int s, input int hp, input int total, input logic [493:0] exp_v,
                       input bit hold, input bit mutate, input int abort_bit);
      int d_exp;
      int nrise, busy_cyc, busy_first, load_first, load_cnt, done_first, done_cnt;
      int run, lvl_err, dat_err, d2;
      logic p_sck, p_sda;
      logic [4:0]   o;
      logic [511:0] got, mask;
      d_exp = 2 * hp * total + hp + 1;
      nrise = 0; busy_cyc = 0; busy_first = -1; load_first = -1; load_cnt = 0;
      done_first = -1; done_cnt = 0; run = 0; lvl_err = 0; dat_err = 0;
      p_sck = 1'b0; p_sda = 1'b0; got = '0;
      set_cfg(s, exp_v);
      @(negedge clock);
      xs[s] = 1'b1;
      @(posedge clock);
      for (int c = 1; c <= d_exp; c++) begin
         #1;
         if (c == 1 && !hold) xs[s] = 1'b0;
         if (mutate && c == 10) set_cfg(s, ~exp_v);
         o = outs(s);
         if (o[4]) begin busy_cyc++; if (busy_first < 0) busy_first = c; end
         if (o[0]) begin load_cnt++; if (load_first < 0) load_first = c; end
         if (o[3]) begin done_cnt++; if (done_first < 0) done_first = c; end
         if (c > 1 && o[2] != p_sck) begin
            if (run != hp) lvl_err++;
            run = 1;
         end else begin
            run++;
         end
         if (c > 1 && o[2] && o[1] != p_sda) dat_err++;
         if (o[2] && !p_sck) begin nrise++; got = {got[510:0], o[1]}; end
         p_sck = o[2];
         p_sda = o[1];
         if (abort_bit > 0 && nrise == abort_bit) begin
            #1 resetb = 1'b0;
            #1 chk("abort_outs_zero", 512'(outs(s)), 512'(0));
            repeat (6) begin
               @(posedge clock); #1;
               o = outs(s);
               if (o[0]) load_cnt++;
               if (o[3]) done_cnt++;
            end
            chk("abort_no_load", 512'(load_cnt), 512'(0));
            chk("abort_no_done", 512'(done_cnt), 512'(0));
            mask = (512'd1 << abort_bit) - 512'd1;
            chk("abort_prefix", got & mask, 512'(exp_v) >> (total - abort_bit));
            @(negedge clock);
            resetb = 1'b1;
            return;
         end
         @(posedge clock);
      end
      #1;
      chk("idle_after_done", 512'(outs(s)), 512'(0));
      chk("n_rising_edges", 512'(nrise), 512'(total));
      chk("bit_stream", got, 512'(exp_v));
      chk("busy_first_cyc", 512'(busy_first), 512'(1));
      chk("busy_cycles", 512'(busy_cyc), 512'(d_exp - 1));
      chk("load_first_cyc", 512'(load_first), 512'(2 * hp * total + 1));
      chk("load_cycles", 512'(load_cnt), 512'(hp));
      chk("done_cyc", 512'(done_first), 512'(d_exp));
      chk("done_count", 512'(done_cnt), 512'(1));
      chk("sclk_level_len", 512'(lvl_err), 512'(0));
      chk("sdata_stable_hi", 512'(dat_err), 512'(0));
      if (hold) begin
         @(posedge clock); #1;
         chk("b2b_busy", 512'(busy_v[s]), 512'(1));
         xs[s] = 1'b0;
         d2 = -1;
         for (int c = d_exp + 2; c <= 2 * d_exp + 5; c++) begin
            if (done_v[s] && d2 < 0) d2 = c;
            @(posedge clock); #1;
         end
         chk("b2b_done_cyc", 512'(d2), 512'(2 * d_exp + 1));
      end
   endtask

   initial begin
      int nz;
      #2 resetb = 1'b0;
      #1 chk("reset_outs", 512'({outs(0), outs(1), outs(2)}), 512'(0));
      repeat (3) @(posedge clock);
      @(negedge clock);
      resetb = 1'b1;
      nz = 0;
      repeat (100) begin
         @(posedge clock); #1;
         if ({outs(0), outs(1), outs(2)} != 15'd0) nz++;
      end
      chk("idle_100_cycles", 512'(nz), 512'(0));

      // 13 ones, 12 zeros, then a one; load on cycle 53, done on cycle 54
      xfer(0, 1, 26, 494'(26'h3FFE001), 1'b0, 1'b0, 0);
      xfer(1, 1, 494, pat(3), 1'b0, 1'b1, 0);
      xfer(2, 3, 494, pat(11), 1'b0, 1'b0, 0);
      xfer(0, 1, 26, 494'(26'h2A5A3C6), 1'b1, 1'b0, 0);
      xfer(1, 1, 494, pat(29), 1'b0, 1'b0, 100);
      xfer(1, 1, 494, pat(29), 1'b0, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
